vc_input_buffer: RTL and testbench
==================================

Name: vc_input_buffer

Overview:
- Parametrised successor to the router's 8-deep single-queue input buffer.
- Provides NUM_VC independent virtual-channel FIFOs, each DEPTH deep, behind one shared write port, plus per-VC pop, head output, occupancy count, full flag and credit-return pulse.
- Sits at each router input port between the link receiver and the VC allocator/switch arbiter; credit pulses go back to the upstream router.
- Overflow and underflow no longer clear the queue: the offending operation is dropped and a sticky error flag is set.

Parameters:
- DATA_W, 23, flit width (payload/address/target packing unchanged, opaque to this block)
- DEPTH, 8, entries per VC; power of two, ≥2
- NUM_VC, 2, number of virtual channels, ≥1
- Derived (localparam): CNT_W = clog2(DEPTH+1); VC_W = max(1, clog2(NUM_VC))

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  DATA_W  incoming flit
- in_valid  in  1  write strobe for in_data
- in_vc  in  VC_W  target VC for the write
- pop  in  NUM_VC  per-VC pop of head flit
- out_data  out  NUM_VC*DATA_W  head flit of VC v at [v*DATA_W +: DATA_W]
- out_valid  out  NUM_VC  VC v non-empty
- count  out  NUM_VC*CNT_W  occupancy of VC v at [v*CNT_W +: CNT_W], range 0..DEPTH
- full  out  NUM_VC  count[v]==DEPTH
- credit_ret  out  NUM_VC  one-cycle pulse per accepted pop
- overflow_err  out  1  sticky: write dropped
- underflow_err  out  1  sticky: pop on empty VC

Behaviour:
- Reset (rst=1 at posedge):
  - clears all rd/wr pointers, counts, credit_ret, overflow_err and underflow_err
  - storage array is not cleared
  - out_valid=0, out_data=0, count=0, full=0 in the cycle after reset; holds while rst stays high
  - reset asserted mid-traffic discards all queued flits; in_valid/pop in that same cycle are ignored
- Organisation: per-VC circular buffer with DEPTH-entry storage, rd_ptr and wr_ptr (log2(DEPTH) bits, natural wrap) and a count register.
- Head output:
  - out_data[v] = storage[v][rd_ptr[v]] when out_valid[v]=1, else forced to 0
  - a write into an empty VC appears at the head on the next cycle (1-cycle latency, no fall-through)
- Write acceptance for VC w=in_vc requires all of:
  - in_valid=1
  - in_vc < NUM_VC
  - count[w]<DEPTH, or pop[w]=1 with count[w]==DEPTH (write while full with simultaneous pop is legal)
  - on acceptance: storage[w][wr_ptr]<=in_data, wr_ptr++
- Write rejection: in_valid=1 that fails the above → flit dropped, queue unchanged, overflow_err<=1.
- Pop acceptance:
  - pop[v]=1 with count[v]>0 → rd_ptr[v]++, credit_ret[v]<=1 next cycle
  - pop[v]=1 with count[v]==0 → ignored, underflow_err<=1, no credit
  - a write into an empty VC with simultaneous pop is not bypassed: the pop is an underflow and the write is accepted
- Count update per VC: count += accepted_write − accepted_pop; simultaneous accepted write and pop leaves count unchanged.
- VC independence: pops on several VCs in the same cycle are all honoured; a write to VC a never affects VC b.
- Error flags: sticky, cleared only by rst.
- credit_ret: registered, high exactly one cycle per accepted pop, low otherwise.
- Wrap-around: pointers wrap modulo DEPTH; FIFO order preserved across wrap.

Test Plan:
1. Reset, then write 0x000001..0x000008 to VC0 on consecutive cycles → count0 = 1..8, full[0]=1 after the 8th, out_data VC0 = 0x000001, out_valid=2'b01.
2. VC0 full, write 0x0000AA with pop[0]=1 → count0 stays 8, head becomes 0x000002, 0x0000AA is last out, credit_ret[0] pulses once, overflow_err=0.
3. VC0 full, write 0x0000BB with no pop → dropped, count0=8, overflow_err=1 and stays 1; a subsequent pop sequence yields the original order.
4. Pop VC1 while empty → underflow_err=1, count1=0, credit_ret[1]=0; write 0x123 to VC1 → out_valid[1]=1 the next cycle with head 0x123.
5. Interleaved traffic across 20 cycles to both VCs, including simultaneous pop[1:0]=2'b11 and wrap past DEPTH → per-VC output order equals write order, credit_ret count equals pop count per VC.
6. Assert rst with VC0 count=5 and in_valid=1 in the same cycle → next cycle all counts 0, out_valid=0, errors 0, no write retained.

Source files
------------

// File: rtl/vc_input_buffer.sv
// Router input buffer: NUM_VC independent circular FIFOs behind one shared write port,
// with per-VC pop, head output, occupancy, full flag, credit return and sticky error flags.
module vc_input_buffer #(
    parameter int  DATA_W = 23,
    parameter int  DEPTH  = 8,
    parameter int  NUM_VC = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    input  logic [VC_W-1:0]          in_vc,
    input  logic [NUM_VC-1:0]        pop,
    output logic [NUM_VC*DATA_W-1:0] out_data,
    output logic [NUM_VC-1:0]        out_valid,
    output logic [NUM_VC*CNT_W-1:0]  count,
    output logic [NUM_VC-1:0]        full,
    output logic [NUM_VC-1:0]        credit_ret,
    output logic                     overflow_err,
    output logic                     underflow_err
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem    [NUM_VC][DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr [NUM_VC];
    logic [PTR_W-1:0]  r_wr_ptr [NUM_VC];
    logic [CNT_W-1:0]  r_count  [NUM_VC];
    logic [NUM_VC-1:0] r_credit;
    logic              r_overflow;
    logic              r_underflow;

    logic [NUM_VC-1:0] w_nonempty;
    logic [NUM_VC-1:0] w_wr_acc;
    logic [NUM_VC-1:0] w_pop_acc;

    // A full VC still takes a write when its head leaves in the same cycle.
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            w_nonempty[v] = (r_count[v] != '0);
            w_wr_acc[v]   = in_valid && (in_vc == VC_W'(v)) &&
                            ((r_count[v] != FULL_CNT) || pop[v]);
            w_pop_acc[v]  = pop[v] && w_nonempty[v];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                r_rd_ptr[v] <= '0;
                r_wr_ptr[v] <= '0;
                r_count[v]  <= '0;
            end
            r_credit    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (w_wr_acc[v])  r_wr_ptr[v] <= r_wr_ptr[v] + PTR_W'(1);
                if (w_pop_acc[v]) r_rd_ptr[v] <= r_rd_ptr[v] + PTR_W'(1);
                r_count[v] <= r_count[v] + CNT_W'(w_wr_acc[v]) - CNT_W'(w_pop_acc[v]);
            end
            r_credit <= w_pop_acc;
            if (in_valid && !(|w_wr_acc))  r_overflow  <= 1'b1;
            if (|(pop & ~w_nonempty))      r_underflow <= 1'b1;
        end
    end

    // NOTE: storage has no reset; cleared pointers and counts make stale entries unreachable.
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (!rst && w_wr_acc[v]) r_mem[v][r_wr_ptr[v]] <= in_data;
        end
    end

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        out_data  = '0;
        count     = '0;
        full      = '0;
        out_valid = w_nonempty;
        for (int v = 0; v < NUM_VC; v++) begin
            out_data[v*DATA_W +: DATA_W] = w_nonempty[v] ? r_mem[v][r_rd_ptr[v]] : '0;
            count[v*CNT_W +: CNT_W]      = r_count[v];
            full[v]                      = (r_count[v] == FULL_CNT);
        end
    end

    assign credit_ret    = r_credit;
    assign overflow_err  = r_overflow;
    assign underflow_err = r_underflow;
endmodule

// File: tb/tb_vc_input_buffer.sv
// Directed bench for vc_input_buffer (DATA_W=23, DEPTH=8, NUM_VC=2) with immediate-assertion checks.
module tb_vc_input_buffer;
    localparam int DW = 23;
    localparam int CW = 4;
    localparam int NV = 2;

    logic             clk;
    logic             rst;
    logic [DW-1:0]    in_data;
    logic             in_valid;
    logic [0:0]       in_vc;
    logic [NV-1:0]    pop;
    logic [NV*DW-1:0] out_data;
    logic [NV-1:0]    out_valid;
    logic [NV*CW-1:0] count;
    logic [NV-1:0]    full;
    logic [NV-1:0]    credit_ret;
    logic             overflow_err;
    logic             underflow_err;

    int vectors     = 0;
    int miscompares = 0;

    int mq [2][$];
    int exp_cred [2];
    int obs_cred [2];

    vc_input_buffer #(.DATA_W(DW), .DEPTH(8), .NUM_VC(NV)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_vc(in_vc),
        .pop(pop), .out_data(out_data), .out_valid(out_valid), .count(count), .full(full),
        .credit_ret(credit_ret), .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] cnt(input int v);
        return 32'(count[v*CW +: CW]);
    endfunction

    function automatic logic [31:0] head(input int v);
        return 32'(out_data[v*DW +: DW]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic vc, input int d, input logic [1:0] p);
        in_valid = v;
        in_vc    = vc;
        in_data  = DW'(d);
        pop      = p;
    endtask

    // One cycle against the queue model: heads checked before the edge, credits/counts after.
    task automatic model_cycle(input logic v, input logic vc, input int d, input logic [1:0] p);
        logic [1:0] pacc;
        logic       wacc;
        int         sz;
        for (int c = 0; c < 2; c++) begin
            check($sformatf("valid%0d", c), 32'(out_valid[c]), 32'(mq[c].size() != 0));
            if (mq[c].size() != 0) check($sformatf("head%0d", c), head(c), 32'(mq[c][0]));
            pacc[c] = p[c] && (mq[c].size() != 0);
        end
        sz   = mq[vc].size();
        wacc = v && ((sz < 8) || (p[vc] && sz == 8));
        drive(v, vc, d, p);
        tick();
        for (int c = 0; c < 2; c++) begin
            if (pacc[c]) void'(mq[c].pop_front());
            exp_cred[c] += int'(pacc[c]);
            obs_cred[c] += int'(credit_ret[c]);
        end
        if (wacc) mq[vc].push_back(d & 32'h7F_FFFF);
        check("credit", 32'(credit_ret), 32'(pacc));
        check("cnt0", cnt(0), 32'(mq[0].size()));
        check("cnt1", cnt(1), 32'(mq[1].size()));
    endtask

    initial begin
        int exp_order [8];
        exp_order = '{32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'hAA};
        exp_cred  = '{0, 0};
        obs_cred  = '{0, 0};

        // 1. reset, then fill VC0
        rst = 1'b1;
        drive(1'b0, 1'b0, 0, 2'b00);
        tick();
        check("rst_count", 32'(count), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data", 32'(out_data[31:0]), 32'h0);
        check("rst_full", 32'(full), 32'h0);
        check("rst_errs", {30'b0, overflow_err, underflow_err}, 32'h0);
        check("rst_credit", 32'(credit_ret), 32'h0);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b0, i, 2'b00);
            tick();
            check($sformatf("fill_cnt%0d", i), cnt(0), 32'(i));
            check("fill_head", head(0), 32'h1);
        end
        drive(1'b0, 1'b0, 0, 2'b00);
        check("fill_full", 32'(full), 32'h1);
        check("fill_valid", 32'(out_valid), 32'h1);

        // 2. write while full with simultaneous pop
        drive(1'b1, 1'b0, 32'hAA, 2'b01);
        tick();
        check("wp_cnt", cnt(0), 32'h8);
        check("wp_head", head(0), 32'h2);
        check("wp_credit", 32'(credit_ret), 32'h1);
        check("wp_ovf", 32'(overflow_err), 32'h0);
        drive(1'b0, 1'b0, 0, 2'b00);
        tick();
        check("wp_credit_off", 32'(credit_ret), 32'h0);

        // 3. overflow drop, then drain in order
        drive(1'b1, 1'b0, 32'hBB, 2'b00);
        tick();
        check("ovf_cnt", cnt(0), 32'h8);
        check("ovf_flag", 32'(overflow_err), 32'h1);
        drive(1'b0, 1'b0, 0, 2'b00);
        tick();
        check("ovf_sticky", 32'(overflow_err), 32'h1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("drain_head%0d", k), head(0), 32'(exp_order[k]));
            drive(1'b0, 1'b0, 0, 2'b01);
            tick();
            check("drain_credit", 32'(credit_ret), 32'h1);
        end
        drive(1'b0, 1'b0, 0, 2'b00);
        check("drain_cnt", cnt(0), 32'h0);
        check("drain_valid", 32'(out_valid), 32'h0);
        check("drain_udf", 32'(underflow_err), 32'h0);

        // 4. underflow on VC1, then write with a non-bypassed pop
        drive(1'b0, 1'b0, 0, 2'b10);
        tick();
        check("udf_flag", 32'(underflow_err), 32'h1);
        check("udf_cnt1", cnt(1), 32'h0);
        check("udf_credit", 32'(credit_ret), 32'h0);
        drive(1'b1, 1'b1, 32'h123, 2'b10);
        tick();
        check("wr1_valid", 32'(out_valid), 32'h2);
        check("wr1_head", head(1), 32'h123);
        check("wr1_cnt", cnt(1), 32'h1);
        check("wr1_credit", 32'(credit_ret), 32'h0);
        check("wr1_head0_zero", head(0), 32'h0);

        // 5. interleaved traffic with wrap, then drain both VCs
        mq[1].push_back(32'h123);
        for (int k = 0; k < 20; k++) begin
            logic [1:0] p;
            logic       vc;
            vc = (k < 10) ? 1'b1 : 1'(k % 2);
            p  = (k < 6) ? 2'b00 : (k % 3 == 0) ? 2'b11 : (k % 3 == 1) ? 2'b10 : 2'b01;
            model_cycle(k % 4 != 3, vc, 32'h300 + k, p);
        end
        for (int k = 0; k < 10; k++) model_cycle(1'b0, 1'b0, 0, 2'b11);
        check("credits_vc0", 32'(obs_cred[0]), 32'(exp_cred[0]));
        check("credits_vc1", 32'(obs_cred[1]), 32'(exp_cred[1]));
        check("empty_after", 32'(out_valid), 32'h0);

        // 6. reset mid-traffic with a write and pop in the same cycle
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 32'h600 + i, 2'b00);
            tick();
        end
        check("pre_rst_cnt", cnt(0), 32'h5);
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h555, 2'b01);
        tick();
        check("mid_rst_count", 32'(count), 32'h0);
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_errs", {30'b0, overflow_err, underflow_err}, 32'h0);
        check("mid_rst_data", 32'(out_data[31:0]), 32'h0);
        check("mid_rst_credit", 32'(credit_ret), 32'h0);
        tick();
        check("rst_hold_cnt", cnt(0), 32'h0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 0, 2'b00);
        tick();
        check("post_rst_cnt", cnt(0), 32'h0);
        check("post_rst_valid", 32'(out_valid), 32'h0);
        drive(1'b1, 1'b0, 32'h777, 2'b00);
        tick();
        check("post_rst_head", head(0), 32'h777);
        check("post_rst_cnt1", cnt(0), 32'h1);
        drive(1'b0, 1'b0, 0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
